uart_rx_led_latch: RTL and testbench

//  - UART receiver (8 data bits, LSB first, 1 stop bit) that sits directly upstream of the LED-array shifter.
//  - Each byte received without error is latched onto data_out, which drives the shifter's 8-bit data input.
//  - data_out stays stable between frames, so the shifter can sample it at any refresh without a handshake.

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx_led_latch.sv | 159 +++++++++++++++
 tb/tb_uart_rx_led_latch.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and baud-divider helper for the UART
// receiver that feeds the LED-array shifter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

  // System clocks per bit; truncating divide, the same way the line is timed.
  function automatic int clks_per_bit(input int sysclk_f, input int baud);
    return sysclk_f / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous input.
// RST_VAL sets what both flops load during reset (1 for an idle-high line).
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; only sync_q is safe to use downstream.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_led_latch.sv
// uart_rx_led_latch: UART receiver (LED_CT data bits, LSB first, 1 stop bit)
// whose last good byte is held on data_out for the LED shifter.
// Optional feature macro: UART_PARITY_EN adds an even-parity bit after the
// data bits; when undefined the frame is 8N1 and parity_err is tied 0.
module uart_rx_led_latch
  import uart_pkg::*;
#(
  parameter int SYSCLK_F = 12000000,
  parameter int BAUD     = 9600,
  parameter int LED_CT   = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              uart_rx,
  output logic [LED_CT-1:0] data_out,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              parity_err
);

  localparam int CPB = clks_per_bit(SYSCLK_F, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam int BW  = $clog2(LED_CT + 1);

  localparam logic [CW-1:0] CNT_MID  = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(CPB - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(LED_CT - 1);

  // Mid-bit sampling needs at least a few clocks per bit to be meaningful.
  generate
    if (CPB < 4) begin : g_bad_baud
      $error("uart_rx_led_latch: CLKS_PER_BIT must be >= 4");
    end
  endgenerate

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .d_i    (uart_rx),
    .q_o    (rx_s)
  );

  uart_state_e       state_q;
  logic [CW-1:0]     cnt_q;
  logic [BW-1:0]     bit_q;
  logic [LED_CT-1:0] shift_q;
  logic [LED_CT-1:0] data_q;
  logic              valid_q;
  logic              ferr_q;
`ifdef UART_PARITY_EN
  logic              perr_q;
  logic              par_bad_q;
`endif

  // Receive FSM: timing counter, bit counter, shift register and all
  // registered outputs; pulse outputs default low every cycle.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
      perr_q  <= 1'b0;
`endif
      cnt_q   <= cnt_q + CW'(1);
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          bit_q <= '0;
          if (!rx_s) state_q <= START;
        end
        // Re-check the line half a bit in to reject glitches.
        START: begin
          if (cnt_q == CNT_MID) begin
            cnt_q   <= '0;
            state_q <= rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt_q == CNT_END) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[LED_CT-1:1]};
            bit_q   <= bit_q + BW'(1);
            if (bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end
        end
`ifdef UART_PARITY_EN
        // Even parity: the parity bit must equal the XOR of the data bits.
        PARITY: begin
          if (cnt_q == CNT_END) begin
            cnt_q     <= '0;
            par_bad_q <= rx_s ^ (^shift_q);
            state_q   <= STOP;
          end
        end
`endif
        // Leave at mid-stop so a back-to-back start edge is not missed.
        STOP: begin
          if (cnt_q == CNT_END) begin
            cnt_q <= '0;
            if (!rx_s) begin
              ferr_q  <= 1'b1;
              state_q <= BREAK;
            end
`ifdef UART_PARITY_EN
            else if (par_bad_q) begin
              perr_q  <= 1'b1;
              state_q <= IDLE;
            end
`endif
            else begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        // Line held low past the stop bit: wait for it to idle again.
        BREAK: begin
          cnt_q <= '0;
          if (rx_s) state_q <= IDLE;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_out  = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
`ifdef UART_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_led_latch.sv
// tb_uart_rx_led_latch: directed plus randomized frames against a
// byte-level model of what the receiver should report.
module tb_uart_rx_led_latch;

  localparam int SYSCLK_F = 160000;
  localparam int BAUD     = 10000;
  localparam int CPB      = SYSCLK_F / BAUD;   // 16 clocks per bit
  localparam int PERIOD   = 10;
`ifdef UART_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       uart_rx;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;

  uart_rx_led_latch #(.SYSCLK_F(SYSCLK_F), .BAUD(BAUD), .LED_CT(8)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .uart_rx    (uart_rx),
    .data_out   (data_out),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #(PERIOD/2) sys_clk = ~sys_clk;

  int vectors     = 0;
  int miscompares = 0;

  // Pulse monitor, sampled on the falling edge.
  int  n_valid = 0, n_ferr = 0, n_perr = 0, n_wide = 0, n_overlap = 0;
  logic prev_v = 1'b0, prev_f = 1'b0, prev_p = 1'b0;
  time t_valid = 0;
  always @(negedge sys_clk) begin
    if (rx_valid) begin n_valid++; t_valid = $time; end
    if (frame_err)  n_ferr++;
    if (parity_err) n_perr++;
    if ((rx_valid && prev_v) || (frame_err && prev_f) || (parity_err && prev_p)) n_wide++;
    if (rx_valid && (frame_err || parity_err)) n_overlap++;
    prev_v = rx_valid; prev_f = frame_err; prev_p = parity_err;
  end

  // Reference model: what the receiver should have reported so far.
  int         exp_valid = 0, exp_ferr = 0, exp_perr = 0;
  logic [7:0] exp_data  = 8'h00;
  time        t_start   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (CPB) tick();
  endtask

  // Sends one frame and updates the model with its expected outcome.
  task automatic send_frame(input logic [7:0] b, input bit stop_v, input bit par_flip,
                            input int low_hold, input int gap);
    t_start = $time;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR) drive_bit((^b) ^ par_flip);
    drive_bit(stop_v);
    if (!stop_v) begin
      repeat (low_hold) tick();
      uart_rx = 1'b1;
      repeat (CPB) tick();
    end
    uart_rx = 1'b1;
    repeat (gap) tick();
    if (!stop_v)                exp_ferr++;
    else if (PAR && par_flip)   exp_perr++;
    else begin exp_valid++; exp_data = b; end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".data"},  {24'h0, data_out}, {24'h0, exp_data});
    check({tag, ".nvld"},  n_valid, exp_valid);
    check({tag, ".nferr"}, n_ferr,  exp_ferr);
    check({tag, ".nperr"}, n_perr,  exp_perr);
  endtask

  initial begin
    int lat;
    logic [7:0] rb;
    bit sb, pf;

    sys_rst_n = 1'b0;
    uart_rx   = 1'b1;
    repeat (3) tick();
    check("rst.data",  {24'h0, data_out}, 32'h0);
    check("rst.vld",   {31'h0, rx_valid}, 32'h0);
    check("rst.ferr",  {31'h0, frame_err}, 32'h0);
    check("rst.perr",  {31'h0, parity_err}, 32'h0);
    sys_rst_n = 1'b1;
    repeat (4) tick();

    // Single good frame; latency about 9.5 bit times + 3 clocks.
    send_frame(8'hA5, 1'b1, 1'b0, 0, 4);
    lat = int'((t_valid - t_start) / PERIOD);
    check("a5.lat_ok", {31'h0, (lat >= CPB*19/2 + 1 && lat <= CPB*19/2 + 5)}, 32'h1);
    check_model("a5");

    // Short low glitch: rejected at mid-start.
    uart_rx = 1'b0;
    repeat (5) tick();
    uart_rx = 1'b1;
    repeat (2*CPB) tick();
    check_model("glitch");

    // Bad stop bit with the line held low, then a good frame.
    send_frame(8'h5A, 1'b0, 1'b0, 4*CPB, 8);
    check_model("ferr");
    send_frame(8'h01, 1'b1, 1'b0, 0, 4);
    check_model("after_ferr");

    // Back-to-back frames with zero idle time.
    send_frame(8'hFF, 1'b1, 1'b0, 0, 0);
    send_frame(8'h00, 1'b1, 1'b0, 0, 4);
    check_model("b2b");

    // Reset for 2 cycles in the middle of bit 4 of 0x3C (bit 4 is 1);
    // the transmitter is abandoned as well and the line idles.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h3C >> i));
    uart_rx = 1'b1;
    repeat (CPB/2) tick();
    sys_rst_n = 1'b0;
    repeat (2) tick();
    check("midrst.data", {24'h0, data_out}, 32'h0);
    check("midrst.vld",  {31'h0, rx_valid}, 32'h0);
    sys_rst_n = 1'b1;
    exp_data = 8'h00;
    repeat (3*CPB) tick();
    check_model("midrst");
    send_frame(8'h3C, 1'b1, 1'b0, 0, 4);
    check_model("after_rst");

    // Even parity: correct parity bit, then a flipped one.
    if (PAR) begin
      send_frame(8'h07, 1'b1, 1'b0, 0, 4);
      check_model("par_ok");
      send_frame(8'h07, 1'b1, 1'b1, 0, 4);
      check_model("par_bad");
    end

    // Randomized frames: random byte, gap, occasional bad stop / parity.
    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom);
      sb = ($urandom_range(7) != 0);
      pf = PAR && ($urandom_range(5) == 0);
      send_frame(rb, sb, pf, $urandom_range(3*CPB, CPB), $urandom_range(20));
      check_model($sformatf("rnd%0d", n));
    end

    check("pulse_width", n_wide, 0);
    check("pulse_overlap", n_overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
